// File: rtl/fetch_stage.sv
// Instruction fetch stage: registered PC, one-entry output bundle toward
// decode, and a RUN/HALT controller that stops fetching after a faulting
// fetch until a redirect arrives.
// Optional build macro: FETCH_MISALIGN_CHECK_EN enables detection of
// misaligned fetch addresses (pc[1:0] != 0).
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] pc_addr,
  input  logic [31:0] imem_instr,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  output logic        id_exc_en,
  output logic [3:0]  id_exc_code,
  output logic [63:0] id_exc_val
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  logic [0:0]  state;
  logic [63:0] pc;
  logic        fire;
  logic        misalign;
  logic        fault;

  assign pc_addr = pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign = (pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // A fetch is launched when running, the output slot is free or draining,
  // and no redirect is pending this cycle.
  always_comb begin
    fire  = (state == RUN) && (!id_valid || id_ready) && !redirect_en;
    fault = misalign || imem_exc_en;
  end

  // PC, FSM and output bundle update; priority rst > redirect > fire > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      state       <= RUN;
      id_valid    <= 1'b0;
      id_instr    <= NOP_INSTR;
      id_pc       <= '0;
      id_exc_en   <= 1'b0;
      id_exc_code <= '0;
      id_exc_val  <= '0;
    end else if (redirect_en) begin
      pc       <= redirect_pc;
      state    <= RUN;
      id_valid <= 1'b0;
    end else if (fire) begin
      id_valid <= 1'b1;
      id_pc    <= pc;
      if (fault) begin
        // Faulting fetch: PC stays on the faulting address, the bundle
        // carries a NOP plus the cause, and fetching stops until redirect.
        // Misalignment takes precedence over a memory fault.
        state     <= HALT;
        id_instr  <= NOP_INSTR;
        id_exc_en <= 1'b1;
        if (misalign) begin
          id_exc_code <= 4'd0;
          id_exc_val  <= pc;
        end else begin
          id_exc_code <= imem_exc_code;
          id_exc_val  <= imem_exc_val;
        end
      end else begin
        pc          <= pc + 64'd4;
        id_instr    <= imem_instr;
        id_exc_en   <= imem_exc_en;
        id_exc_code <= imem_exc_code;
        id_exc_val  <= imem_exc_val;
      end
    end else if (id_valid && id_ready) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_0000_0000, PC loaded on reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pc_addr  output  64  current fetch PC to instruction memory, driven directly from the PC register.
REQ-005 imem_instr  input  32  instruction word returned combinationally for pc_addr.
REQ-006 imem_exc_en / imem_exc_code / imem_exc_val  input  1/4/64  memory access-fault indication, cause and faulting address.
REQ-007 redirect_en  input  1  PC redirect request (taken branch, jump, trap entry, mret).
REQ-008 redirect_pc  input  64  redirect target.
REQ-009 id_ready  input  1  decode stage accepts the current bundle this cycle.
REQ-010 id_valid  output  1  fetch bundle valid.
REQ-011 id_instr / id_pc  output  32/64  registered instruction and its PC.
REQ-012 id_exc_en / id_exc_code / id_exc_val  output  1/4/64  registered exception carried with the bundle.

Function
REQ-013 Registered PC, output bundle, and a two-state FSM: RUN, HALT.
REQ-014 Fetch fire = state RUN and (!id_valid or id_ready) and !redirect_en.
REQ-015 On fire: id_valid<=1; id_instr<=imem_instr; id_pc<=pc; id_exc_*<=imem_exc_*; single-cycle latency from pc_addr to bundle.
REQ-016 On fire with imem_exc_en=0: pc<=pc+4, modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC wraps to 0).
REQ-017 On fire with imem_exc_en=1: pc unchanged, state<=HALT; id_instr captured as 32'h0000_0013.
REQ-018 In HALT, no fire; when id_valid and id_ready, id_valid<=0; the faulting bundle is emitted exactly once.
REQ-019 No fire and no handshake: pc and all id_* outputs hold their values.
REQ-020 id_valid and !id_ready and no redirect: stall, no PC advance.
REQ-021 redirect_en=1: pc<=redirect_pc, id_valid<=0 (flush), state<=RUN, regardless of id_ready or state; no fire that cycle.
REQ-022 Priority: rst > redirect_en > fire > hold.
REQ-023 id_valid=0 outputs: id_exc_en=0 is not guaranteed; consumers qualify all fields with id_valid.

Reset
REQ-024 On rst at a clock edge: pc<=RESET_PC, state<=RUN, id_valid<=0, id_instr<=32'h0000_0013, id_pc<=0, id_exc_en<=0, id_exc_code<=0, id_exc_val<=0.
REQ-025 Reset mid-stall, mid-HALT or coincident with redirect_en yields the reset state only; first fire occurs the cycle after rst deasserts.

Configuration
REQ-026 Macro FETCH_MISALIGN_CHECK_EN selects instruction-address-misaligned detection.
REQ-027 Defined: a fire with pc[1:0]!=0 captures id_exc_en=1, id_exc_code=4'd0, id_exc_val=pc, id_instr=32'h0000_0013, enters HALT; it overrides any imem exception that cycle.
REQ-028 Not defined: pc[1:0] is not checked and is passed unchanged on pc_addr.

Verification
REQ-029 Reset with RESET_PC=0, id_ready=1 held -> id_pc sequence 0,4,8,12 on consecutive cycles, id_valid=1 from second cycle after reset release.
REQ-030 id_ready=0 for 3 cycles with bundle at pc=8 -> id_pc=8, id_instr stable, pc_addr stays 12; on release, next bundle pc=12.
REQ-031 redirect_en with redirect_pc=0x100 while stalled -> next cycle id_valid=0, pc_addr=0x100; following cycle id_pc=0x100.
REQ-032 imem_exc_en=1, code 1, val 0x2000 at pc 0x2000 -> one bundle id_exc_en=1, code 1, val 0x2000, instr 0x13; then id_valid=0 until redirect to 0x80 resumes at 0x80.
REQ-033 With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> bundle id_exc_en=1, code 0, val 0x102, then HALT; without macro, bundle id_pc=0x102, id_exc_en=0.
REQ-034 rst asserted in HALT with redirect_en=1 -> pc_addr=RESET_PC, id_valid=0, state RUN next cycle.
